dual_issue_fetch_queue: RTL and testbench

- Instruction pair buffer between the fetch stage and the dual-issue decode stage.
- Accepts 0–2 fetched instructions per cycle and presents the two oldest as an ordered issue pair with per-slot valids.
- Retires 0, 1 or 2 per cycle according to the decode stage's single/dual-issue decision.
- Circular buffer with independent head/tail pointers, occupancy counter and flush.

---
 rtl/dual_issue_fetch_queue.sv | 109 ++++++++++
 tb/tb_dual_issue_fetch_queue.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dual_issue_fetch_queue.sv
// Circular instruction-pair buffer between fetch and dual-issue decode.
// Accepts 0-2 instructions per cycle and presents the two oldest, with PCs, as an ordered issue pair.
module dual_issue_fetch_queue #(
  parameter int els_p         = 8,
  parameter int instr_width_p = 32,
  parameter int pc_width_p    = 22
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         flush_i,
  input  logic [1:0]                   enq_v_i,
  input  logic [2*instr_width_p-1:0]   enq_instr_i,
  input  logic [pc_width_p-1:0]        enq_pc_i,
  output logic                         enq_ready_o,
  output logic [1:0]                   deq_v_o,
  output logic [2*instr_width_p-1:0]   deq_instr_o,
  output logic [2*pc_width_p-1:0]      deq_pc_o,
  input  logic [1:0]                   deq_yumi_i,
  output logic [$clog2(els_p+1)-1:0]   count_o
);

  localparam int ptr_w = $clog2(els_p);
  localparam int cnt_w = $clog2(els_p+1);

  logic [instr_width_p-1:0] instr_mem [els_p];
  logic [pc_width_p-1:0]    pc_mem    [els_p];

  logic [ptr_w-1:0] head, tail, head_1, tail_1;
  logic [cnt_w-1:0] count, count_nxt;
  logic [cnt_w:0]   count_wide;
  logic [1:0]       enq_n, deq_n;
  logic             enq_go;

  assign head_1 = head + ptr_w'(1);
  assign tail_1 = tail + ptr_w'(1);

  // Readiness looks only at registered occupancy, so yumi never reaches enq_ready_o.
  assign enq_ready_o = (count <= cnt_w'(els_p - 2));
  assign enq_go      = enq_ready_o && !flush_i;
  assign enq_n       = enq_ready_o ? ({1'b0, enq_v_i[0]} + {1'b0, enq_v_i[1]}) : 2'd0;
  assign deq_n       = {1'b0, deq_yumi_i[0]} + {1'b0, deq_yumi_i[1]};

  assign count_wide = {1'b0, count} + (cnt_w+1)'(enq_n) - (cnt_w+1)'(deq_n);
  assign count_nxt  = count_wide[cnt_w-1:0];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + ptr_w'(deq_n);
      tail  <= tail + ptr_w'(enq_n);
      count <= count_nxt;
    end
  end

  // Storage is data only and carries no reset.
  always_ff @(posedge clk_i) begin
    if (enq_go) begin
      if (enq_v_i[0]) begin
        instr_mem[tail] <= enq_instr_i[instr_width_p-1:0];
        pc_mem[tail]    <= enq_pc_i;
      end
      if (enq_v_i[1]) begin
        instr_mem[tail_1] <= enq_instr_i[2*instr_width_p-1:instr_width_p];
        pc_mem[tail_1]    <= enq_pc_i + pc_width_p'(1);
      end
    end
  end

  assign deq_v_o = {(count >= cnt_w'(2)), (count != '0)};

  always_comb begin
    deq_instr_o = '0;
    deq_pc_o    = '0;
    if (deq_v_o[0]) begin
      deq_instr_o[instr_width_p-1:0] = instr_mem[head];
      deq_pc_o[pc_width_p-1:0]       = pc_mem[head];
    end
    if (deq_v_o[1]) begin
      deq_instr_o[2*instr_width_p-1:instr_width_p] = instr_mem[head_1];
      deq_pc_o[2*pc_width_p-1:pc_width_p]          = pc_mem[head_1];
    end
  end

  assign count_o = count;

  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(deq_yumi_i[1] && !deq_yumi_i[0]))
        else $error("illegal yumi pattern %b", deq_yumi_i);
      assert ((deq_yumi_i & ~deq_v_o) == 2'b00)
        else $error("yumi %b exceeds deq_v %b", deq_yumi_i, deq_v_o);
      assert (enq_v_i != 2'b10)
        else $error("illegal enq_v pattern %b", enq_v_i);
      if (!flush_i) begin
        // A negative result wraps to a large value, so one bound covers underflow and overflow.
        assert (count_wide <= (cnt_w+1)'(els_p))
          else $error("occupancy out of range");
      end
    end
  end

endmodule

// File: tb/tb_dual_issue_fetch_queue.sv
// Directed bench for dual_issue_fetch_queue with hand-computed expectations (els_p = 8).
module tb_dual_issue_fetch_queue;

  localparam int IW = 32;
  localparam int PW = 22;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          flush = 1'b0;
  logic [1:0]    enq_v = 2'b00;
  logic [2*IW-1:0] enq_instr = '0;
  logic [PW-1:0] enq_pc = '0;
  logic          enq_ready;
  logic [1:0]    deq_v;
  logic [2*IW-1:0] deq_instr;
  logic [2*PW-1:0] deq_pc;
  logic [1:0]    deq_yumi = 2'b00;
  logic [3:0]    count;

  int checks = 0;
  int errors = 0;
  int next_exp;

  dual_issue_fetch_queue #(.els_p(8), .instr_width_p(IW), .pc_width_p(PW)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush),
    .enq_v_i(enq_v), .enq_instr_i(enq_instr), .enq_pc_i(enq_pc),
    .enq_ready_o(enq_ready), .deq_v_o(deq_v), .deq_instr_o(deq_instr),
    .deq_pc_o(deq_pc), .deq_yumi_i(deq_yumi), .count_o(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_enq(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                         input logic [PW-1:0] pc);
    enq_v     = v;
    enq_instr = {i1, i0};
    enq_pc    = pc;
  endtask

  task automatic chk_pair(input string tag, input logic [1:0] v, input logic [31:0] i0,
                          input logic [31:0] i1);
    chk({tag, "_v"}, 64'(deq_v), 64'(v));
    chk({tag, "_instr"}, deq_instr, {i1, i0});
  endtask

  initial begin
    // 1: reset holds the queue empty even with enqueue requested
    set_enq(2'b11, 32'h1, 32'h2, 22'h0);
    step(); step();
    chk("rst_v", 64'(deq_v), 64'h0);
    chk("rst_count", 64'(count), 64'h0);
    chk("rst_ready", 64'(enq_ready), 64'h1);
    chk("rst_instr", deq_instr, 64'h0);
    chk("rst_pc", 64'(deq_pc), 64'h0);
    reset_n = 1'b1;
    set_enq(2'b11, 32'hA, 32'hB, 22'h100);
    step();
    set_enq(2'b00, 32'h0, 32'h0, 22'h0);
    chk_pair("t1", 2'b11, 32'hA, 32'hB);
    chk("t1_pc", 64'(deq_pc), 64'({22'h101, 22'h100}));
    chk("t1_count", 64'(count), 64'd2);

    // 2: single-issue then dual-issue drain
    set_enq(2'b01, 32'hC, 32'h0, 22'h102);
    step();
    set_enq(2'b00, 32'h0, 32'h0, 22'h0);
    chk("t2_count3", 64'(count), 64'd3);
    deq_yumi = 2'b01;
    step();
    chk_pair("t2_after01", 2'b11, 32'hB, 32'hC);
    chk("t2_pc", 64'(deq_pc), 64'({22'h102, 22'h101}));
    chk("t2_count2", 64'(count), 64'd2);
    deq_yumi = 2'b11;
    step();
    deq_yumi = 2'b00;
    chk_pair("t2_empty", 2'b00, 32'h0, 32'h0);
    chk("t2_count0", 64'(count), 64'd0);

    // 3: fill to full starting at index 3 (storage wraps), extra pair is dropped
    for (int k = 0; k < 4; k++) begin
      set_enq(2'b11, 32'h10 + 32'(2*k), 32'h11 + 32'(2*k), 22'(22'h200 + 22'(2*k)));
      step();
    end
    chk("t3_count8", 64'(count), 64'd8);
    chk("t3_ready0", 64'(enq_ready), 64'h0);
    set_enq(2'b11, 32'hEE, 32'hEF, 22'h300);
    step();
    set_enq(2'b00, 32'h0, 32'h0, 22'h0);
    chk("t3_drop_count", 64'(count), 64'd8);
    chk_pair("t3_head", 2'b11, 32'h10, 32'h11);
    chk("t3_pc", 64'(deq_pc), 64'({22'h201, 22'h200}));
    deq_yumi = 2'b11;
    step(); step(); step();
    chk_pair("t3_last", 2'b11, 32'h16, 32'h17);
    step();
    deq_yumi = 2'b00;
    chk("t3_drained", 64'(count), 64'd0);

    // 4: flush to index 0, then a stream offset by one so pair reads and writes straddle 7->0
    flush = 1'b1;
    step();
    flush = 1'b0;
    set_enq(2'b01, 32'd1, 32'd0, 22'h0);
    step();
    chk_pair("t4_first", 2'b01, 32'd1, 32'd0);
    next_exp = 1;
    for (int k = 0; k < 9; k++) begin
      if (k == 0) begin
        chk("t4_s0", 64'(deq_instr[31:0]), 64'(next_exp));
        deq_yumi = 2'b01;
      end else begin
        chk_pair("t4_stream", 2'b11, 32'(next_exp), 32'(next_exp + 1));
        deq_yumi = 2'b11;
      end
      set_enq(2'b11, 32'(2 + 2*k), 32'(3 + 2*k), 22'h0);
      step();
      next_exp = next_exp + ((k == 0) ? 1 : 2);
    end
    chk_pair("t4_tailpair", 2'b11, 32'd18, 32'd19);
    deq_yumi = 2'b11;
    set_enq(2'b01, 32'd20, 32'd0, 22'h0);
    step();
    chk_pair("t4_twenty", 2'b01, 32'd20, 32'd0);
    chk("t4_count1", 64'(count), 64'd1);
    set_enq(2'b00, 32'h0, 32'h0, 22'h0);
    deq_yumi = 2'b01;
    step();
    deq_yumi = 2'b00;
    chk("t4_empty", 64'(count), 64'd0);

    // 5: simultaneous enqueue/dequeue at the readiness boundary
    for (int k = 0; k < 3; k++) begin
      set_enq(2'b11, 32'h30 + 32'(2*k), 32'h31 + 32'(2*k), 22'h0);
      step();
    end
    chk("t5_count6", 64'(count), 64'd6);
    chk("t5_ready6", 64'(enq_ready), 64'h1);
    set_enq(2'b11, 32'h36, 32'h37, 22'h0);
    deq_yumi = 2'b01;
    step();
    chk("t5_count7", 64'(count), 64'd7);
    chk("t5_ready7", 64'(enq_ready), 64'h0);
    chk_pair("t5_head7", 2'b11, 32'h31, 32'h32);
    set_enq(2'b01, 32'h99, 32'h0, 22'h0);
    deq_yumi = 2'b00;
    step();
    chk("t5_single_drop", 64'(count), 64'd7);
    set_enq(2'b11, 32'h40, 32'h41, 22'h0);
    deq_yumi = 2'b11;
    step();
    deq_yumi = 2'b00;
    set_enq(2'b00, 32'h0, 32'h0, 22'h0);
    chk("t5_count5", 64'(count), 64'd5);
    chk("t5_ready5", 64'(enq_ready), 64'h1);
    chk_pair("t5_head5", 2'b11, 32'h33, 32'h34);

    // 6: flush overrides same-cycle enqueue and dequeue, then async reset mid-cycle
    flush = 1'b1;
    set_enq(2'b11, 32'h77, 32'h78, 22'h0);
    deq_yumi = 2'b11;
    step();
    flush = 1'b0;
    deq_yumi = 2'b00;
    set_enq(2'b00, 32'h0, 32'h0, 22'h0);
    chk("t6_flush_count", 64'(count), 64'd0);
    chk_pair("t6_flush_deq", 2'b00, 32'h0, 32'h0);
    set_enq(2'b11, 32'h50, 32'h51, 22'h40);
    step();
    set_enq(2'b01, 32'h52, 32'h0, 22'h42);
    step();
    set_enq(2'b00, 32'h0, 32'h0, 22'h0);
    chk("t6_refill", 64'(count), 64'd3);
    chk_pair("t6_refill_deq", 2'b11, 32'h50, 32'h51);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_v", 64'(deq_v), 64'h0);
    chk("t6_async_count", 64'(count), 64'd0);
    chk("t6_async_instr", deq_instr, 64'h0);
    step();
    reset_n = 1'b1;
    set_enq(2'b11, 32'h60, 32'h61, 22'h80);
    step();
    set_enq(2'b00, 32'h0, 32'h0, 22'h0);
    chk_pair("t6_post_reset", 2'b11, 32'h60, 32'h61);
    chk("t6_post_pc", 64'(deq_pc), 64'({22'h81, 22'h80}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
